// File: rtl/bump_conditioner.sv
// Bumper input conditioner: per channel a 2-flop synchronizer, a counter-based
// debounce and a minimum-assertion stretch so that even a short qualifying bump
// stays low across at least one edge of the slow bump-reaction FSM clock.

module bump_channel #(
    parameter int DEBOUNCE_CYCLES = 20800,
    parameter int HOLD_CYCLES     = 2200000,
    parameter int CW              = 22
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic bump,
    output logic evt
);

    // State bit 1 is the "pressed" flag, so the conditioned output is one
    // flop bit and cannot glitch while the state register changes.
    localparam logic [1:0] REL  = 2'b00;
    localparam logic [1:0] DB_P = 2'b01;
    localparam logic [1:0] PRS  = 2'b10;
    localparam logic [1:0] DB_R = 2'b11;

    localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] hcnt;

    // Two-flop synchronizer; idles high because the switch is active-low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // Debounce/stretch state machine with its debounce and hold counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= REL;
            cnt   <= '0;
            hcnt  <= '0;
            evt   <= 1'b0;
        end else begin
            evt <= 1'b0;
            case (state)
                REL: begin
                    if (!s2) begin
                        state <= DB_P;
                        cnt   <= '0;
                    end
                end
                DB_P: begin
                    if (s2) begin
                        state <= REL;
                    end else if (cnt == DB_LAST) begin
                        state <= PRS;
                        hcnt  <= '0;
                        evt   <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PRS: begin
                    if (hcnt != HOLD_LAST) begin
                        hcnt <= hcnt + 1'b1;
                    end
                    if (s2 && (hcnt == HOLD_LAST)) begin
                        state <= DB_R;
                        cnt   <= '0;
                    end
                end
                DB_R: begin
                    if (!s2) begin
                        state <= PRS;
                    end else if (cnt == DB_LAST) begin
                        state <= REL;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= REL;
                end
            endcase
        end
    end

    assign bump = ~state[1];

endmodule

module bump_conditioner #(
    parameter int DEBOUNCE_CYCLES = 20800,
    parameter int HOLD_CYCLES     = 2200000,
    parameter int CW              = 22
) (
    input  logic clk,
    input  logic reset,
    input  logic R_raw,
    input  logic L_raw,
    output logic R_bump,
    output logic L_bump,
    output logic R_evt,
    output logic L_evt
);

    bump_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .HOLD_CYCLES     (HOLD_CYCLES),
        .CW              (CW)
    ) u_right (
        .clk   (clk),
        .reset (reset),
        .raw   (R_raw),
        .bump  (R_bump),
        .evt   (R_evt)
    );

    bump_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .HOLD_CYCLES     (HOLD_CYCLES),
        .CW              (CW)
    ) u_left (
        .clk   (clk),
        .reset (reset),
        .raw   (L_raw),
        .bump  (L_bump),
        .evt   (L_evt)
    );

endmodule

// File: tb/tb_bump_conditioner.sv
// Testbench for bump_conditioner: directed scenarios followed by random bumper
// activity, compared every cycle against a run-length reference model.

module tb_bump_conditioner;

    localparam int DEB  = 4;
    localparam int HOLD = 10;

    logic clk;
    logic reset;
    logic R_raw;
    logic L_raw;
    logic R_bump;
    logic L_bump;
    logic R_evt;
    logic L_evt;

    int compared;
    int mismatched;
    int l_low_cycles;
    int l_evt_count;

    bump_conditioner #(
        .DEBOUNCE_CYCLES (DEB),
        .HOLD_CYCLES     (HOLD),
        .CW              (8)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .R_raw  (R_raw),
        .L_raw  (L_raw),
        .R_bump (R_bump),
        .L_bump (L_bump),
        .R_evt  (R_evt),
        .L_evt  (L_evt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model, channel 0 = right, 1 = left. A change is accepted after
    // DEB+1 consecutive synchronized samples at the new level; while pressed,
    // high samples only count toward release once HOLD edges have passed.
    logic m_q1[2];
    logic m_q2[2];
    logic m_raw[2];
    logic m_seen;
    int   m_low_run[2];
    int   m_high_run[2];
    int   m_age[2];
    bit   m_pressed[2];
    bit   m_evt[2];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < 2; c++) begin
                m_q1[c]       = 1'b1;
                m_q2[c]       = 1'b1;
                m_low_run[c]  = 0;
                m_high_run[c] = 0;
                m_age[c]      = 0;
                m_pressed[c]  = 1'b0;
                m_evt[c]      = 1'b0;
            end
        end else begin
            m_raw[0] = R_raw;
            m_raw[1] = L_raw;
            for (int c = 0; c < 2; c++) begin
                m_seen   = m_q2[c];
                m_q2[c]  = m_q1[c];
                m_q1[c]  = m_raw[c];
                m_evt[c] = 1'b0;
                if (!m_pressed[c]) begin
                    m_low_run[c] = m_seen ? 0 : m_low_run[c] + 1;
                    if (m_low_run[c] == DEB + 1) begin
                        m_pressed[c]  = 1'b1;
                        m_evt[c]      = 1'b1;
                        m_age[c]      = 0;
                        m_high_run[c] = 0;
                        m_low_run[c]  = 0;
                    end
                end else begin
                    if (m_age[c] < HOLD) m_age[c]++;
                    if (m_seen && m_age[c] >= HOLD) m_high_run[c]++;
                    else m_high_run[c] = 0;
                    if (m_high_run[c] == DEB + 1) begin
                        m_pressed[c]  = 1'b0;
                        m_high_run[c] = 0;
                        m_low_run[c]  = 0;
                    end
                end
            end
        end
    end

    task automatic compareBit(input string tag, input logic obs, input logic exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic compareInt(input string tag, input int obs, input int exp);
        compared++;
        assert (obs == exp)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic checkOutput();
        compareBit("R_bump", R_bump, !m_pressed[0]);
        compareBit("L_bump", L_bump, !m_pressed[1]);
        compareBit("R_evt", R_evt, m_evt[0]);
        compareBit("L_evt", L_evt, m_evt[1]);
        if (L_bump === 1'b0) l_low_cycles++;
        if (L_evt === 1'b1) l_evt_count++;
    endtask

    task automatic applyStimulus(input logic r, input logic l, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checkOutput();
            R_raw = r;
            L_raw = l;
        end
    endtask

    task automatic pulseReset();
        @(negedge clk);
        checkOutput();
        #3 reset = 1'b0;
        #1;
        compareBit("async_R_bump", R_bump, 1'b1);
        compareBit("async_L_bump", L_bump, 1'b1);
        compareBit("async_R_evt", R_evt, 1'b0);
        compareBit("async_L_evt", L_evt, 1'b0);
        @(negedge clk);
        checkOutput();
        reset = 1'b1;
    endtask

    initial begin
        logic r_lvl;
        logic l_lvl;
        int   r_left;
        int   l_left;

        compared     = 0;
        mismatched   = 0;
        l_low_cycles = 0;
        l_evt_count  = 0;
        reset        = 1'b0;
        R_raw        = 1'b1;
        L_raw        = 1'b1;

        $display("[TB] reset held with raw inputs toggling");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1);
            compareBit("rst_R_bump", R_bump, 1'b1);
            compareBit("rst_L_evt", L_evt, 1'b0);
        end
        applyStimulus(1'b1, 1'b1, 1);
        reset = 1'b1;
        applyStimulus(1'b1, 1'b1, 6);

        $display("[TB] right press held");
        applyStimulus(1'b0, 1'b1, 7);
        @(negedge clk);
        checkOutput();
        compareBit("press_R_bump", R_bump, 1'b0);
        compareBit("press_R_evt", R_evt, 1'b1);
        compareBit("press_L_bump", L_bump, 1'b1);
        @(negedge clk);
        checkOutput();
        compareBit("press_R_evt_end", R_evt, 1'b0);
        applyStimulus(1'b0, 1'b1, 12);
        applyStimulus(1'b1, 1'b1, 25);

        $display("[TB] right glitches shorter than debounce");
        applyStimulus(1'b0, 1'b1, 3);
        applyStimulus(1'b1, 1'b1, 5);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 1'b1, 3);
            applyStimulus(1'b1, 1'b1, 1);
        end
        applyStimulus(1'b1, 1'b1, 5);

        $display("[TB] short left press stretched");
        l_low_cycles = 0;
        l_evt_count  = 0;
        applyStimulus(1'b1, 1'b0, 5);
        applyStimulus(1'b1, 1'b1, 25);
        compareInt("stretch_low_cycles", l_low_cycles, HOLD + DEB);
        compareInt("stretch_evt_count", l_evt_count, 1);

        $display("[TB] left release bounce");
        l_evt_count = 0;
        applyStimulus(1'b1, 1'b0, 20);
        applyStimulus(1'b1, 1'b1, 2);
        applyStimulus(1'b1, 1'b0, 3);
        compareBit("bounce_L_bump", L_bump, 1'b0);
        applyStimulus(1'b1, 1'b1, 20);
        compareInt("bounce_evt_count", l_evt_count, 1);
        compareBit("bounce_released", L_bump, 1'b1);

        $display("[TB] simultaneous press and reset mid-press");
        applyStimulus(1'b0, 1'b0, 7);
        @(negedge clk);
        checkOutput();
        compareBit("both_R_evt", R_evt, 1'b1);
        compareBit("both_L_evt", L_evt, 1'b1);
        applyStimulus(1'b0, 1'b0, 4);
        pulseReset();
        applyStimulus(1'b0, 1'b0, 20);
        applyStimulus(1'b1, 1'b1, 25);

        $display("[TB] random bumper activity");
        r_lvl  = 1'b1;
        l_lvl  = 1'b1;
        r_left = 1;
        l_left = 1;
        for (int i = 0; i < 3000; i++) begin
            if (--r_left == 0) begin
                r_lvl  = ~r_lvl;
                r_left = r_lvl ? $urandom_range(1, 25) : $urandom_range(1, 8);
            end
            if (--l_left == 0) begin
                l_lvl  = ~l_lvl;
                l_left = l_lvl ? $urandom_range(1, 25) : $urandom_range(1, 8);
            end
            if ($urandom_range(0, 499) == 0) pulseReset();
            applyStimulus(r_lvl, l_lvl, 1);
        end
        applyStimulus(1'b1, 1'b1, 30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
